// File: rtl/dac_sample_sequencer_pkg.sv
// Shared types and DAC command-word layout for the sample sequencer.
package dac_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOW  = 2'd1,
    WAIT_HIGH = 2'd2
  } seq_state_t;

  localparam int CH_BIT   = 15;
  localparam int GA_BIT   = 13;
  localparam int SHDN_BIT = 12;
  localparam int DATA_LSB = 4;
  localparam int DATA_W   = 8;

  // Channel A, bit 14 unused, low nibble of the word is always zero.
  function automatic logic [15:0] build_frame(input logic gain, input logic shdn,
                                              input logic [DATA_W-1:0] sample);
    logic [15:0] f;
    f = '0;
    f[CH_BIT] = 1'b0;
    f[GA_BIT] = gain;
    f[SHDN_BIT] = shdn;
    f[DATA_LSB +: DATA_W] = sample;
    return f;
  endfunction

endpackage

// File: rtl/dac_sample_sequencer_sync_fifo.sv
// Single-clock FIFO; read data is combinational from the head entry.
// A push is accepted while full only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (level == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dac_sample_sequencer.sv
// Paces buffered samples out to the SPI DAC stage at a fixed rate; st_rise/frame one cycle after the tick.
// s_ready drops only when the sample FIFO is full; ticks during a frame are dropped and flagged.
module dac_sample_sequencer
  import dac_pkg::*;
#(
  parameter int RATE_DIV    = 1000,
  parameter int FIFO_DEPTH  = 8,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        s_valid,
  input  logic [7:0]                  s_data,
  output logic                        s_ready,
  input  logic                        gain_x1,
  input  logic                        shdn_n,
  input  logic                        spi_ncs,
  output logic                        st_rise,
  output logic [15:0]                 frame,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        underrun,
  output logic                        overrun,
  output logic                        no_ack,
  input  logic                        err_clr
);

  localparam int CW = $clog2(RATE_DIV);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  seq_state_t        state;
  logic [CW-1:0]     cnt;
  logic [TW-1:0]     to_cnt;
  logic [DATA_W-1:0] last_sample;
  logic [DATA_W-1:0] fifo_data;
  logic [DATA_W-1:0] sample_sel;
  logic              tick;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;

  assign tick       = enable & (cnt == CW'(RATE_DIV - 1));
  assign s_ready    = ~fifo_full;
  assign fifo_push  = s_valid & s_ready;
  assign fifo_pop   = (state == IDLE) & tick & ~fifo_empty;
  assign sample_sel = fifo_empty ? last_sample : fifo_data;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (s_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst || !enable || tick) cnt <= '0;
    else                        cnt <= cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      to_cnt      <= '0;
      st_rise     <= 1'b0;
      frame       <= '0;
      last_sample <= '0;
      underrun    <= 1'b0;
      overrun     <= 1'b0;
      no_ack      <= 1'b0;
    end else begin
      st_rise <= 1'b0;
      // Clear first so that any set condition below in the same cycle wins.
      if (err_clr) begin
        underrun <= 1'b0;
        overrun  <= 1'b0;
        no_ack   <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (tick) begin
            if (fifo_empty) underrun    <= 1'b1;
            else            last_sample <= fifo_data;
            frame   <= build_frame(gain_x1, shdn_n, sample_sel);
            st_rise <= 1'b1;
            to_cnt  <= '0;
            state   <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!spi_ncs) begin
            state <= WAIT_HIGH;
          end else if (to_cnt == TW'(ACK_TIMEOUT - 1)) begin
            no_ack <= 1'b1;
            state  <= IDLE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        WAIT_HIGH: begin
          if (spi_ncs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (tick && state != IDLE) overrun <= 1'b1;
    end
  end

endmodule
